// File: rtl/multicycle_control.sv
// multicycle_control
// Main control unit for a multi-cycle MIPS datapath. It is a Moore FSM that
// steps the shared ALU, register file, PC and unified memory through fetch,
// decode, execute, memory and writeback cycles.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   opcode        IR[31:26], stable from DECODE until the instruction retires
//   zero          ALU zero flag, used by BRANCH
//   mem_ready     memory completes the access this cycle
//   pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, alu_op, pc_source
//                 datapath mux selects and write enables
//   illegal_op    one-cycle flag for an unsupported opcode
//   state         current state encoding, for debug
//   instr_count   retired-instruction count, wraps modulo 2^COUNT_WIDTH
//
// The outputs are decoded combinationally from the state register. Only the
// memory-ready-qualified enables and the branch pc_write also look at inputs.
// All control outputs are gated by rst_n, so reset silences the datapath
// immediately rather than at the next edge.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic                   illegal_op,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_r;
  state_t next_state_s;
  logic   retire_s;
  logic [COUNT_WIDTH-1:0] instr_count_r;

  logic       pc_write_s, iord_s, mem_read_s, mem_write_s, ir_write_s;
  logic       reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s, illegal_op_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter; illegal opcodes never retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_r <= '0;
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  // Next-state, retire strobe and Moore output decode.
  always_comb begin
    next_state_s = S_FETCH;
    retire_s     = 1'b0;
    pc_write_s   = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    pc_source_s  = 2'b00;
    illegal_op_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s   = 1'b1;
        alu_src_b_s  = 2'b01;
        // IR load and PC+4 only in the cycle the memory delivers.
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        next_state_s = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_b_s = 2'b11;
        case (opcode)
          OP_RTYPE:       next_state_s = S_EXECUTE;
          OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
          OP_J:           next_state_s = S_JUMP;
          OP_ADDI:        next_state_s = S_ADDI_EXEC;
          default:        next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        next_state_s = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_s   = 1'b1;
        iord_s       = 1'b1;
        next_state_s = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s  = 1'b1;
        iord_s       = 1'b1;
        retire_s     = mem_ready;
        next_state_s = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b10;
        next_state_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b01;
        pc_source_s  = 2'b01;
        // opcode[0] distinguishes bne (1) from beq (0).
        pc_write_s   = zero ^ opcode[0];
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b10;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        next_state_s = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op_s = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  assign pc_write    = rst_n & pc_write_s;
  assign iord        = rst_n & iord_s;
  assign mem_read    = rst_n & mem_read_s;
  assign mem_write   = rst_n & mem_write_s;
  assign ir_write    = rst_n & ir_write_s;
  assign reg_dst     = rst_n & reg_dst_s;
  assign mem_to_reg  = rst_n & mem_to_reg_s;
  assign reg_write   = rst_n & reg_write_s;
  assign alu_src_a   = rst_n & alu_src_a_s;
  assign alu_src_b   = rst_n ? alu_src_b_s : 2'b00;
  assign alu_op      = rst_n ? alu_op_s    : 2'b00;
  assign pc_source   = rst_n ? pc_source_s : 2'b00;
  assign illegal_op  = rst_n & illegal_op_s;
  assign state       = state_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Randomized self-checking bench. The reference model describes each
// instruction as its list of phases (state numbers); memory phases repeat
// while mem_ready is low. Expected control words come from a per-state
// table written straight from the control description, with the
// ready/zero-dependent bits filled in per cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
  logic        mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_count = 32'd0;
  logic [15:0] ctrl_tbl [0:15];

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Control word: [15]pc_write [14]iord [13]mem_read [12]mem_write
  // [11]ir_write [10]reg_dst [9]mem_to_reg [8]reg_write [7]alu_src_a
  // [6:5]alu_src_b [4:3]alu_op [2:1]pc_source [0]illegal_op
  function automatic logic [15:0] ctrl_now();
    return {pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_mem_phase(input int p);
    return (p == 0) || (p == 3) || (p == 5);
  endfunction

  // Phase list of one instruction, from the instruction-class sequences.
  function automatic void phases_of(input logic [5:0] op, output int q[$],
                                    output bit retires);
    retires = 1'b1;
    case (op)
      6'b000000: q = '{0, 1, 6, 7};
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000100, 6'b000101: q = '{0, 1, 8};
      6'b000010: q = '{0, 1, 9};
      6'b001000: q = '{0, 1, 10, 11};
      default: begin q = '{0, 1, 12}; retires = 1'b0; end
    endcase
  endfunction

  // Called at a negedge: drive, check, advance to the next negedge.
  task automatic step(input int p, input logic rdy, input logic z);
    logic [15:0] exp_ctrl;
    mem_ready = rdy;
    zero      = z;
    exp_ctrl  = ctrl_tbl[p];
    if (p == 0) begin
      exp_ctrl[15] = rdy;
      exp_ctrl[11] = rdy;
    end else if (p == 8) begin
      exp_ctrl[15] = z ^ opcode[0];
    end
    #1;
    check("state", 32'(state), 32'(p));
    check("ctrl", 32'(ctrl_now()), 32'(exp_ctrl));
    check("count", instr_count, exp_count);
    @(negedge clk);
  endtask

  // fixed_stall >= 0: no fetch stall, that many data-phase stalls.
  // fixed_stall < 0: random stalls on every memory phase.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int fixed_stall);
    int q[$];
    bit retires;
    int stalls;
    opcode = op;
    phases_of(op, q, retires);
    foreach (q[i]) begin
      if (is_mem_phase(q[i])) begin
        if (fixed_stall >= 0) stalls = (q[i] == 0) ? 0 : fixed_stall;
        else stalls = int'($urandom_range(0, 2));
        for (int s = 0; s <= stalls; s++) step(q[i], s == stalls, z);
      end else begin
        step(q[i], 1'($urandom_range(0, 1)), z);
      end
    end
    if (retires) exp_count = exp_count + 32'd1;
  endtask

  initial begin
    logic [5:0] op_pool [0:8];
    logic [5:0] op;
    for (int i = 0; i < 16; i++) ctrl_tbl[i] = 16'h0000;
    ctrl_tbl[0]  = 16'b0010_0000_0010_0000; // mem_read, alu_src_b=01
    ctrl_tbl[1]  = 16'b0000_0000_0110_0000; // alu_src_b=11
    ctrl_tbl[2]  = 16'b0000_0000_1100_0000; // alu_src_a, alu_src_b=10
    ctrl_tbl[3]  = 16'b0110_0000_0000_0000; // iord, mem_read
    ctrl_tbl[4]  = 16'b0000_0011_0000_0000; // mem_to_reg, reg_write
    ctrl_tbl[5]  = 16'b0101_0000_0000_0000; // iord, mem_write
    ctrl_tbl[6]  = 16'b0000_0000_1001_0000; // alu_src_a, alu_op=10
    ctrl_tbl[7]  = 16'b0000_0101_0000_0000; // reg_dst, reg_write
    ctrl_tbl[8]  = 16'b0000_0000_1000_1010; // alu_src_a, alu_op=01, pc_source=01
    ctrl_tbl[9]  = 16'b1000_0000_0000_0100; // pc_write, pc_source=10
    ctrl_tbl[10] = 16'b0000_0000_1100_0000; // alu_src_a, alu_src_b=10
    ctrl_tbl[11] = 16'b0000_0001_0000_0000; // reg_write
    ctrl_tbl[12] = 16'b0000_0000_0000_0001; // illegal_op
    op_pool[0] = 6'b000000; op_pool[1] = 6'b100011; op_pool[2] = 6'b101011;
    op_pool[3] = 6'b000100; op_pool[4] = 6'b000101; op_pool[5] = 6'b000010;
    op_pool[6] = 6'b001000; op_pool[7] = 6'b111111; op_pool[8] = 6'b010001;

    rst_n = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b100011;
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl_now()), 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: lw, R-type, beq/bne with zero=1, sw with 3 stalls, illegal.
    run_instr(6'b100011, 1'b0, 0);
    check("lw_count", instr_count, 32'd1);
    run_instr(6'b000000, 1'b0, 0);
    run_instr(6'b000100, 1'b1, 0);
    run_instr(6'b000101, 1'b1, 0);
    run_instr(6'b101011, 1'b0, 3);
    run_instr(6'b111111, 1'b0, 0);
    run_instr(6'b001000, 1'b0, 0);
    run_instr(6'b000010, 1'b0, 0);

    // Reset asserted during a stalled MEM_READ.
    opcode = 6'b100011;
    step(0, 1'b1, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1 check("mr_state", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_ctrl", 32'(ctrl_now()), 32'd0);
    check("arst_count", instr_count, 32'd0);
    exp_count = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized instruction stream with random stalls and zero flag.
    for (int n = 0; n < 80; n++) begin
      op = op_pool[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      run_instr(op, 1'($urandom_range(0, 1)), -1);
    end
    step(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
